// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB3 register file with wait states, error response, read-only status and write pulses
// Ports: clk/rst (async, active-low); PSEL/PENABLE/PWRITE/PADDR/PWDATA APB request;
//        PRDATA/PREADY/PSLVERR APB response (registered); status_in feeds read-only regs;
//        regs_out exposes register contents; wr_pulse strobes one cycle after a committed write.
// Option: define APB_REGFILE_PSTRB_EN to add the PSTRB port and byte-lane writes.
module apb_regfile_slave #(
  parameter int AMBA_WORD = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int NUM_REGS = 4,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            PSEL,
  input  logic                            PENABLE,
  input  logic                            PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0]      PADDR,
  input  logic [AMBA_WORD-1:0]            PWDATA,
`ifdef APB_REGFILE_PSTRB_EN
  input  logic [AMBA_WORD/8-1:0]          PSTRB,
`endif
  output logic [AMBA_WORD-1:0]            PRDATA,
  output logic                            PREADY,
  output logic                            PSLVERR,
  input  logic [NUM_REGS*AMBA_WORD-1:0]   status_in,
  output logic [NUM_REGS*AMBA_WORD-1:0]   regs_out,
  output logic [NUM_REGS-1:0]             wr_pulse
);
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d, dec_idx;
  logic wr_q, wr_d, err_q, err_d, dec_err, dec_valid, enter, commit;
  logic [AMBA_WORD-1:0] prdata_q, prdata_d, wdata;
  logic pready_q, pslverr_q;
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic [NUM_REGS-1:0][AMBA_WORD-1:0] regs_q, status_v;
  assign status_v = status_in;
  assign regs_out = regs_q;
  assign PRDATA = prdata_q;
  assign PREADY = pready_q;
  assign PSLVERR = pslverr_q;
  assign wr_pulse = wr_pulse_q;
  assign dec_idx = PADDR[IDX_W+1:2];
  assign dec_valid = PADDR[1:0] == 2'b00 && 32'(dec_idx) < NUM_REGS && (PADDR >> (IDX_W + 2)) == '0;
`ifdef APB_REGFILE_PSTRB_EN
  assign dec_err = !dec_valid || (PWRITE && RO_MASK[dec_idx]) || (!PWRITE && |PSTRB);
`else
  assign dec_err = !dec_valid || (PWRITE && RO_MASK[dec_idx]);
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    wr_d = wr_q;
    err_d = err_q;
    unique case (state_q)
      S_IDLE: if (PSEL && !PENABLE) begin
        idx_d = dec_idx;
        wr_d = PWRITE;
        err_d = dec_err;
        cnt_d = CNT_INIT;
        state_d = WAIT_STATES == 0 ? S_READY : S_WAIT;
      end
      S_WAIT: begin
        state_d = !PSEL ? S_IDLE : cnt_q == '0 ? S_READY : S_WAIT;
        cnt_d = PSEL && cnt_q != '0 ? cnt_q - 4'd1 : cnt_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // Response is computed from the next-state decode so the zero-wait path can enter READY straight from IDLE.
  assign enter = state_d == S_READY && state_q != S_READY;
  assign prdata_d = enter && !wr_d && !err_d ? (RO_MASK[idx_d] ? status_v[idx_d] : regs_q[idx_d]) : '0;
  assign commit = state_q == S_READY && wr_q && !err_q;
  always_comb begin
    wdata = PWDATA;
`ifdef APB_REGFILE_PSTRB_EN
    for (int b = 0; b < AMBA_WORD / 8; b++) wdata[8*b +: 8] = PSTRB[b] ? PWDATA[8*b +: 8] : regs_q[idx_q][8*b +: 8];
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      prdata_q <= '0;
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      wr_pulse_q <= '0;
      regs_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      wr_q <= wr_d;
      err_q <= err_d;
      prdata_q <= prdata_d;
      pready_q <= enter;
      pslverr_q <= enter && err_d;
      wr_pulse_q <= commit ? NUM_REGS'(1) << idx_q : '0;
      if (commit) regs_q[idx_q] <= wdata;
    end
  end
endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: directed checks of a zero-wait and a three-wait-state register file
module tb_apb_regfile_slave;
  logic clk = 1'b0, rst = 1'b0;
  logic psel0 = 1'b0, psel3 = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [19:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [127:0] status_in = {32'h0000_0055, 96'h0};
  logic [31:0] prdata0, prdata3;
  logic pready0, pready3, pslverr0, pslverr3;
  logic [127:0] regs0, regs3;
  logic [3:0] wr_pulse0, wr_pulse3;
  int n_checks = 0, n_fail = 0;
`ifdef APB_REGFILE_PSTRB_EN
  logic [3:0] pstrb = '0, wstrb = 4'hF, rstrb = '0;
`endif
  always #5 clk = ~clk;
  apb_regfile_slave #(.WAIT_STATES(0), .RO_MASK(4'b1000)) u0 (
    .clk(clk), .rst(rst), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_REGFILE_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0), .status_in(status_in), .regs_out(regs0), .wr_pulse(wr_pulse0)
  );
  apb_regfile_slave #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst), .PSEL(psel3), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_REGFILE_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3), .status_in(status_in), .regs_out(regs3), .wr_pulse(wr_pulse3)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Called at posedge+1; returns at posedge+1 of the cycle after completion, when wr_pulse is visible.
  task automatic xfer(input bit d, input logic w, input logic [19:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    psel0 = !d;
    psel3 = d;
    PENABLE = 1'b0;
    PWRITE = w;
    PADDR = a;
    PWDATA = wd;
`ifdef APB_REGFILE_PSTRB_EN
    pstrb = w ? wstrb : rstrb;
`endif
    @(posedge clk) #1;
    PENABLE = 1'b1;
    lat = 1;
    @(negedge clk);
    while (!(d ? pready3 : pready0) && lat < 20) begin
      @(posedge clk) #1;
      lat++;
      @(negedge clk);
    end
    if (lat >= 20) check("xfer_timeout", d ? pready3 : pready0, 1'b1);
    rd = d ? prdata3 : prdata0;
    er = d ? pslverr3 : pslverr0;
    @(posedge clk) #1;
    psel0 = 1'b0;
    psel3 = 1'b0;
    PENABLE = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    logic er, seen;
    int lat;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pready", pready0, 1'b0);
    check("rst_pslverr", pslverr0, 1'b0);
    check("rst_prdata", prdata0, '0);
    check("rst_regs", regs0, '0);
    check("rst_pulse", wr_pulse0, '0);
    rst = 1'b1;
    xfer(0, 1, 20'h4, 32'hDEAD_BEEF, rd, er, lat);
    check("t1_wr_lat", lat, 1);
    check("t1_wr_err", er, 1'b0);
    check("t1_regs", regs0, {64'h0, 32'hDEAD_BEEF, 32'h0});
    check("t1_pulse", wr_pulse0, 4'b0010);
    @(posedge clk) #1;
    check("t1_pulse_gone", wr_pulse0, 4'b0000);
    xfer(0, 0, 20'h4, 32'h0, rd, er, lat);
    check("t1_rd_data", rd, 32'hDEAD_BEEF);
    check("t1_rd_err", er, 1'b0);
    check("t1_rd_nopulse", wr_pulse0, 4'b0000);
    xfer(0, 1, 20'h0, 32'h1234_5678, rd, er, lat);
    xfer(0, 0, 20'h0, 32'h0, rd, er, lat);
    check("b2b_rd", rd, 32'h1234_5678);
    check("b2b_regs", regs0, {64'h0, 32'hDEAD_BEEF, 32'h1234_5678});
    xfer(0, 1, 20'h10, 32'hFFFF_FFFF, rd, er, lat);
    check("t3_range_err", er, 1'b1);
    check("t3_range_pulse", wr_pulse0, 4'b0000);
    xfer(0, 1, 20'h6, 32'hFFFF_FFFF, rd, er, lat);
    check("t3_misalign_err", er, 1'b1);
    check("t3_misalign_pulse", wr_pulse0, 4'b0000);
    xfer(0, 1, 20'h10004, 32'hFFFF_FFFF, rd, er, lat);
    check("t3_hibits_err", er, 1'b1);
    check("t3_regs", regs0, {64'h0, 32'hDEAD_BEEF, 32'h1234_5678});
    xfer(0, 0, 20'h10, 32'h0, rd, er, lat);
    check("t3_rd_err", er, 1'b1);
    check("t3_rd_zero", rd, 32'h0);
    xfer(0, 0, 20'hC, 32'h0, rd, er, lat);
    check("t4_ro_rd", rd, 32'h55);
    check("t4_ro_rd_err", er, 1'b0);
    status_in[127:96] = 32'h0000_A0A0;
    xfer(0, 0, 20'hC, 32'h0, rd, er, lat);
    check("t4_ro_live", rd, 32'h0000_A0A0);
    xfer(0, 1, 20'hC, 32'h1111_1111, rd, er, lat);
    check("t4_ro_wr_err", er, 1'b1);
    check("t4_ro_wr_pulse", wr_pulse0, 4'b0000);
    check("t4_ro_regs", regs0, {64'h0, 32'hDEAD_BEEF, 32'h1234_5678});
    psel0 = 1'b1;
    PENABLE = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= pready0;
    end
    @(posedge clk) #1;
    psel0 = 1'b0;
    PENABLE = 1'b0;
    @(negedge clk);
    seen |= pready0;
    check("idle_penable_ignored", seen, 1'b0);
    @(posedge clk) #1;
    xfer(1, 1, 20'h8, 32'hCAFE_F00D, rd, er, lat);
    check("t2_wr_lat", lat, 4);
    check("t2_wr_pulse", wr_pulse3, 4'b0100);
    xfer(1, 0, 20'h8, 32'h0, rd, er, lat);
    check("t2_rd_lat", lat, 4);
    check("t2_rd_data", rd, 32'hCAFE_F00D);
    check("t2_rd_err", er, 1'b0);
    psel3 = 1'b1;
    PWRITE = 1'b1;
    PADDR = 20'h0;
    PWDATA = 32'h77;
    @(posedge clk) #1;
    PENABLE = 1'b1;
    @(posedge clk) #1;
    psel3 = 1'b0;
    PENABLE = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= pready3 | (|wr_pulse3);
    end
    check("t5_abort_quiet", seen, 1'b0);
    check("t5_abort_regs", regs3, {32'h0, 32'hCAFE_F00D, 64'h0});
    @(posedge clk) #1;
    psel3 = 1'b1;
    PWDATA = 32'h99;
    @(posedge clk) #1;
    PENABLE = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    #1;
    check("t5_rst_regs3", regs3, '0);
    check("t5_rst_regs0", regs0, '0);
    check("t5_rst_pready", pready3, 1'b0);
    psel3 = 1'b0;
    PENABLE = 1'b0;
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    xfer(1, 1, 20'h4, 32'h5A5A_5A5A, rd, er, lat);
    check("t5_fresh_lat", lat, 4);
    check("t5_fresh_err", er, 1'b0);
    check("t5_fresh_regs", regs3, {64'h0, 32'h5A5A_5A5A, 32'h0});
`ifdef APB_REGFILE_PSTRB_EN
    wstrb = 4'hF;
    xfer(0, 1, 20'h0, 32'h1122_3344, rd, er, lat);
    wstrb = 4'b0101;
    xfer(0, 1, 20'h0, 32'hAABB_CCDD, rd, er, lat);
    check("t6_strb_regs", regs0[31:0], 32'h11BB_33DD);
    wstrb = 4'hF;
    xfer(0, 1, 20'h0, 32'h1, rd, er, lat);
    check("t6_b2b_pulse0", wr_pulse0, 4'b0001);
    xfer(0, 1, 20'h4, 32'h2, rd, er, lat);
    check("t6_b2b_pulse1", wr_pulse0, 4'b0010);
    wstrb = 4'h0;
    xfer(0, 1, 20'h0, 32'hFFFF_FFFF, rd, er, lat);
    check("t6_zero_strb_err", er, 1'b0);
    check("t6_zero_strb_pulse", wr_pulse0, 4'b0001);
    check("t6_zero_strb_regs", regs0[63:0], {32'h2, 32'h1});
    rstrb = 4'h1;
    xfer(0, 0, 20'h0, 32'h0, rd, er, lat);
    check("t6_rd_strb_err", er, 1'b1);
    rstrb = 4'h0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
